// File: rtl/output_stream_reader_pkg.sv
// Shared constants and the FSM state type for the output stream reader.
package output_stream_pkg;

  localparam int DATA_W  = 32;
  localparam int N_WORDS = 4;
  localparam int BLOCK_W = DATA_W * N_WORDS;
  localparam int ADDR_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage : output_stream_pkg

// File: rtl/output_stream_reader_if.sv
// Word stream towards the host: data, word index tag, last flag and valid/ready.
interface output_stream_reader_if #(
  parameter int DATA_W = output_stream_pkg::DATA_W,
  parameter int ADDR_W = output_stream_pkg::ADDR_W
);

  logic [DATA_W-1:0] Out_data;
  logic [ADDR_W-1:0] Out_addr;
  logic              Out_valid;
  logic              Out_ready;
  logic              Out_last;

  // Producer side (the reader)
  modport master (
    output Out_data,
    output Out_addr,
    output Out_valid,
    output Out_last,
    input  Out_ready
  );

  // Consumer side (host / bus)
  modport slave (
    input  Out_data,
    input  Out_addr,
    input  Out_valid,
    input  Out_last,
    output Out_ready
  );

endinterface : output_stream_reader_if

// File: rtl/output_stream_reader.sv
// Captures a result block from the output memory on Start and streams it out
// as N_WORDS words, most significant word first, over a valid/ready handshake.
module output_stream_reader
  import output_stream_pkg::*;
#(
  parameter int DATA_W  = output_stream_pkg::DATA_W,
  parameter int N_WORDS = output_stream_pkg::N_WORDS,
  parameter int ADDR_W  = output_stream_pkg::ADDR_W
) (
  input  logic                        Clock,
  input  logic                        Res,
  input  logic                        Start,
  input  logic                        Abort,
  input  logic [DATA_W*N_WORDS-1:0]   In_block,
  output_stream_reader_if.master      strm,
  output logic                        Busy,
  output logic                        Done
);

  localparam int                BLK_W    = DATA_W * N_WORDS;
  localparam int                OFF_W    = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

  state_t            state_q;
  logic [BLK_W-1:0]  shadow_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic [OFF_W-1:0]  cur_off;
  logic [OFF_W-1:0]  nxt_off;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] nxt_word;

  // Word k sits at bit offset (N_WORDS-1-k)*DATA_W: word0 is the top slice.
  // nxt_* is only consumed while idx_q < N_WORDS-1, so its offset stays in range.
  always_comb begin
    idx_d    = idx_q + ADDR_W'(1);
    cur_off  = OFF_W'((N_WORDS - 1 - int'(idx_q)) * DATA_W);
    nxt_off  = OFF_W'((N_WORDS - 1 - int'(idx_d)) * DATA_W);
    cur_word = shadow_q[cur_off +: DATA_W];
    nxt_word = shadow_q[nxt_off +: DATA_W];
  end

  // Drain FSM with all stream and status outputs registered.
  // The first SEND cycle is a load slot (valid_q still low) that presents word0.
  always_ff @(posedge Clock or posedge Res) begin
    if (Res) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start && !Abort) begin
            shadow_q <= In_block;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end

        SEND: begin
          if (Abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= cur_word;
            addr_q  <= idx_q;
            last_q  <= (idx_q == LAST_IDX);
          end else if (strm.Out_ready) begin
            if (last_q) begin
              state_q <= FINISH;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_d;
              data_q <= nxt_word;
              addr_q <= idx_d;
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end

        FINISH: begin
          // Start is ignored here; Abort needs no action since Done already drops.
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign strm.Out_data  = data_q;
  assign strm.Out_addr  = addr_q;
  assign strm.Out_valid = valid_q;
  assign strm.Out_last  = last_q;
  assign Busy           = busy_q;
  assign Done           = done_q;

endmodule : output_stream_reader

// File: tb/tb_output_stream_reader.sv
// Bench for output_stream_reader: directed scenarios plus randomized drains,
// with the expected word sequence derived from the captured block.
module tb_output_stream_reader;

  logic         Clock;
  logic         Res;
  logic         Start;
  logic         Abort;
  logic [127:0] In_block;
  logic         Busy;
  logic         Done;

  int unsigned checks;
  int unsigned failures;

  output_stream_reader_if #(.DATA_W(32), .ADDR_W(3)) strm ();

  output_stream_reader #(
    .DATA_W (32),
    .N_WORDS(4),
    .ADDR_W (3)
  ) dut (
    .Clock   (Clock),
    .Res     (Res),
    .Start   (Start),
    .Abort   (Abort),
    .In_block(In_block),
    .strm    (strm.master),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, strm.Out_valid, 1'b0);
    chk({tag, "_last"},  strm.Out_last,  1'b0);
    chk({tag, "_busy"},  Busy,           1'b0);
    chk({tag, "_done"},  Done,           1'b0);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input int unsigned k);
    chk({tag, "_valid"}, strm.Out_valid, 1'b1);
    chk({tag, "_data"},  strm.Out_data,  w);
    chk({tag, "_addr"},  strm.Out_addr,  k);
    chk({tag, "_last"},  strm.Out_last,  (k == 3));
    chk({tag, "_busy"},  Busy,           1'b1);
    chk({tag, "_done"},  Done,           1'b0);
  endtask

  // Word k of a block is its k-th 32-bit slice counting from the top.
  function automatic logic [31:0] word_of(input logic [127:0] blk, input int unsigned k);
    logic [127:0] sh;
    sh = blk >> (32 * (3 - k));
    return sh[31:0];
  endfunction

  // One full drain. stall_pct: chance of Out_ready low per cycle.
  // noise: random Start pulses during SEND/FINISH and random In_block after capture.
  task automatic run_drain(input string tag, input logic [127:0] blk,
                           input int unsigned stall_pct, input bit noise);
    logic [31:0] words[$];
    int unsigned k;
    int unsigned budget;
    bit          r;
    words = {};
    for (int unsigned i = 0; i < 4; i++) words.push_back(word_of(blk, i));

    In_block = blk;
    Start    = 1'b1;
    step();
    Start    = 1'b0;
    In_block = noise ? {$urandom(), $urandom(), $urandom(), $urandom()} : '1;
    chk({tag, "_load_valid"}, strm.Out_valid, 1'b0);
    chk({tag, "_load_busy"},  Busy,           1'b1);
    chk({tag, "_load_done"},  Done,           1'b0);
    strm.Out_ready = 1'($urandom_range(1));
    step();

    k = 0;
    budget = 0;
    while (k < 4 && budget < 300) begin
      chk_word(tag, words[k], k);
      r = ($urandom_range(99) >= stall_pct);
      strm.Out_ready = r;
      if (noise) begin
        Start    = 1'($urandom_range(1));
        In_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      step();
      if (r) k++;
      budget++;
    end
    chk({tag, "_words_drained"}, k, 4);

    // FINISH cycle; a Start here must not begin a new drain
    Start = noise;
    chk({tag, "_fin_done"},  Done,           1'b1);
    chk({tag, "_fin_valid"}, strm.Out_valid, 1'b0);
    chk({tag, "_fin_busy"},  Busy,           1'b0);
    strm.Out_ready = 1'b0;
    step();
    Start = 1'b0;
    chk_quiet({tag, "_idle"});
    step();
    chk_quiet({tag, "_idle2"});
  endtask

  initial begin
    logic [127:0] blk;
    checks         = 0;
    failures       = 0;
    Res            = 1'b1;
    Start          = 1'b0;
    Abort          = 1'b0;
    In_block       = '0;
    strm.Out_ready = 1'b0;

    // 1. reset state
    #2;
    chk_quiet("reset");
    chk("reset_data", strm.Out_data, 32'h0);
    chk("reset_addr", strm.Out_addr, 3'd0);
    #10;
    Res = 1'b0;
    step();
    chk_quiet("post_reset");

    // 2. streaming at full rate
    run_drain("stream", 128'h11111111_22222222_33333333_44444444, 0, 1'b0);

    // 3. backpressure at word1
    In_block = 128'h11111111_22222222_33333333_44444444;
    Start = 1'b1;
    step();
    Start = 1'b0;
    strm.Out_ready = 1'b1;
    step();
    chk_word("bp_w0", 32'h11111111, 0);
    step();
    chk_word("bp_w1", 32'h22222222, 1);
    strm.Out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_word("bp_hold", 32'h22222222, 1);
    end
    strm.Out_ready = 1'b1;
    step();
    chk_word("bp_w2", 32'h33333333, 2);
    step();
    chk_word("bp_w3", 32'h44444444, 3);
    step();
    chk("bp_done", Done, 1'b1);
    strm.Out_ready = 1'b0;
    step();
    chk_quiet("bp_idle");

    // 4. capture isolation and Start while busy
    run_drain("iso", 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 20, 1'b1);

    // 5. abort during word2
    In_block = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
    Start = 1'b1;
    step();
    Start = 1'b0;
    strm.Out_ready = 1'b1;
    step();
    step();
    step();
    chk_word("abort_w2", 32'hC2C2C2C2, 2);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    strm.Out_ready = 1'b0;
    chk_quiet("abort_next");
    step();
    chk_quiet("abort_nodone");
    Abort = 1'b1;
    Start = 1'b1;
    step();
    Abort = 1'b0;
    Start = 1'b0;
    chk_quiet("abort_start_idle");
    step();
    chk_quiet("abort_start_idle2");
    run_drain("after_abort", 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, 0, 1'b0);

    // 6. reset mid-drain at word3 with Out_ready low
    In_block = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    Start = 1'b1;
    step();
    Start = 1'b0;
    strm.Out_ready = 1'b1;
    step();
    step();
    step();
    step();
    chk_word("rst_w3", 32'h87654321, 3);
    strm.Out_ready = 1'b0;
    step();
    chk_word("rst_w3_hold", 32'h87654321, 3);
    #2;
    Res = 1'b1;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_data", strm.Out_data, 32'h0);
    chk("rst_mid_addr", strm.Out_addr, 3'd0);
    #3;
    Res = 1'b0;
    step();
    chk_quiet("rst_after");
    run_drain("after_rst", 128'hFEEDFACE_BAADF00D_00000001_80000000, 0, 1'b0);

    // randomized drains
    for (int n = 0; n < 20; n++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_drain("rand", blk, $urandom_range(60), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_output_stream_reader
